// File: rtl/freq_shift_pkg.sv
// Shared helpers for the multi-channel frequency shifter: width derivation,
// sine table generation and the round/saturate step of the complex mixer.
package freq_shift_pkg;

  localparam real PI = 3.14159265358979323846;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  function automatic int unsigned ch_width(input int unsigned n_ch);
    return (n_ch <= 1) ? 1 : clog2(n_ch);
  endfunction

  // round(sin(2*pi*idx/2^aw) * (2^(cw-1)-1)), ties away from zero
  function automatic int sin_coef(input int unsigned idx, input int unsigned aw,
                                  input int unsigned cw);
    real ang;
    real v;
    ang = 2.0 * PI * real'(idx) / real'(64'd1 << aw);
    v   = $sin(ang) * real'((64'd1 << (cw - 1)) - 64'd1);
    return (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
  endfunction

  // Round half-up by frac bits, then clip to a dw-bit signed range.
  function automatic logic signed [63:0] round_sat(input  logic signed [63:0] v,
                                                   input  int unsigned        frac,
                                                   input  int unsigned        dw,
                                                   output logic               sat);
    logic signed [63:0] t;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    t   = (v + (64'sd1 <<< (frac - 1))) >>> frac;
    hi  = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (dw - 1));
    sat = 1'b0;
    if (t > hi) begin
      t   = hi;
      sat = 1'b1;
    end else if (t < lo) begin
      t   = lo;
      sat = 1'b1;
    end
    return t;
  endfunction

endpackage

// File: rtl/nco_sincos_rom.sv
// Phase-to-cos/sin lookup with registered outputs (one clock).
// FREQ_SHIFT_QUARTER_WAVE_EN: quarter-wave sine table with address mirroring.
module nco_sincos_rom
  import freq_shift_pkg::*;
#(
  parameter int unsigned AW = 10,
  parameter int unsigned CW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic [AW-1:0]        i_addr,
  output logic signed [CW-1:0] o_cos,
  output logic signed [CW-1:0] o_sin
);

  localparam int unsigned DEPTH = 1 << AW;

  logic signed [CW-1:0] w_cos;
  logic signed [CW-1:0] w_sin;
  logic signed [CW-1:0] r_cos;
  logic signed [CW-1:0] r_sin;

`ifdef FREQ_SHIFT_QUARTER_WAVE_EN
  localparam int unsigned QD = 1 << (AW - 2);
  localparam logic signed [CW-1:0] PEAK = CW'((64'd1 << (CW - 1)) - 64'd1);

  logic signed [CW-1:0] w_qtbl [QD];
  logic [AW-1:0]        w_lane_addr [2];
  logic signed [CW-1:0] w_lane_val [2];

  for (genvar k = 0; k < QD; k++) begin : g_qtbl
    localparam int SV = sin_coef(k, AW, CW);
    assign w_qtbl[k] = CW'(SV);
  end

  assign w_lane_addr[0] = i_addr;
  assign w_lane_addr[1] = i_addr + AW'(QD);

  // Mirrored quadrants read index Q-m; m=0 there is the peak, which the table lacks.
  for (genvar l = 0; l < 2; l++) begin : g_lane
    logic [1:0]           w_quad;
    logic [AW-3:0]        w_m;
    logic [AW-3:0]        w_mir;
    logic signed [CW-1:0] w_mag;
    logic signed [CW-1:0] w_val;

    assign w_quad = w_lane_addr[l][AW-1 -: 2];
    assign w_m    = w_lane_addr[l][AW-3:0];
    assign w_mir  = -w_m;

    always_comb begin
      w_mag = w_qtbl[w_m];
      if (w_quad[0]) w_mag = (w_m == '0) ? PEAK : w_qtbl[w_mir];
      w_val = w_quad[1] ? -w_mag : w_mag;
    end

    assign w_lane_val[l] = w_val;
  end

  assign w_sin = w_lane_val[0];
  assign w_cos = w_lane_val[1];
`else
  logic signed [CW-1:0] w_sin_tbl [DEPTH];
  logic signed [CW-1:0] w_cos_tbl [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_tbl
    localparam int SV = sin_coef(k, AW, CW);
    localparam int CV = sin_coef((k + DEPTH / 4) % DEPTH, AW, CW);
    assign w_sin_tbl[k] = CW'(SV);
    assign w_cos_tbl[k] = CW'(CV);
  end

  assign w_sin = w_sin_tbl[i_addr];
  assign w_cos = w_cos_tbl[i_addr];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cos <= '0;
      r_sin <= '0;
    end else if (i_en) begin
      r_cos <= w_cos;
      r_sin <= w_sin;
    end
  end

  assign o_cos = r_cos;
  assign o_sin = r_sin;

endmodule

// File: rtl/multich_freq_shifter.sv
// Time-multiplexed N-channel NCO + complex mixer, 4-clock fixed latency.
// FREQ_SHIFT_QUARTER_WAVE_EN selects the quarter-wave table in nco_sincos_rom.
module multich_freq_shifter
  import freq_shift_pkg::*;
#(
  parameter  int unsigned N_CH   = 4,
  parameter  int unsigned DW     = 8,
  parameter  int unsigned PW     = 32,
  parameter  int unsigned ROM_AW = 10,
  parameter  int unsigned CW     = 8,
  localparam int unsigned CHW    = ch_width(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] real_i,
  input  logic signed [DW-1:0] imag_i,
  input  logic [CHW-1:0]       ch_i,
  input  logic                 valid_i,
  input  logic                 cfg_we_i,
  input  logic                 cfg_clr_i,
  input  logic [CHW-1:0]       cfg_ch_i,
  input  logic [PW-1:0]        cfg_delta_i,
  output logic signed [DW-1:0] real_o,
  output logic signed [DW-1:0] imag_o,
  output logic [CHW-1:0]       ch_o,
  output logic                 valid_o,
  output logic                 sat_o
);

  localparam int unsigned PRW = DW + CW;
  localparam int unsigned SW  = PRW + 1;

  logic [PW-1:0]         r_phase [N_CH];
  logic [PW-1:0]         r_delta [N_CH];
  logic [ROM_AW-1:0]     w_addr_sel;

  logic                  r_v0, r_v1, r_v2;
  logic signed [DW-1:0]  r_re0, r_im0, r_re1, r_im1;
  logic [CHW-1:0]        r_ch0, r_ch1, r_ch2;
  logic [ROM_AW-1:0]     r_addr0;
  logic signed [CW-1:0]  w_cos, w_sin;
  logic signed [PRW-1:0] r_xc, r_ys, r_xs, r_yc;
  logic signed [SW-1:0]  w_re_sum, w_im_sum;
  logic signed [DW-1:0]  w_re_q, w_im_q;
  logic                  w_re_sat, w_im_sat;

  // Out-of-range channels fall through with address 0 (phase 0, unshifted).
  always_comb begin
    w_addr_sel = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (ch_i == CHW'(c)) w_addr_sel = r_phase[c][PW-1 -: ROM_AW];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        r_phase[c] <= '0;
        r_delta[c] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        if (cfg_we_i && cfg_ch_i == CHW'(c)) r_delta[c] <= cfg_delta_i;
        if (cfg_clr_i && cfg_ch_i == CHW'(c))
          r_phase[c] <= '0;
        else if (valid_i && ch_i == CHW'(c))
          r_phase[c] <= r_phase[c] + r_delta[c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v0    <= 1'b0;
      r_re0   <= '0;
      r_im0   <= '0;
      r_ch0   <= '0;
      r_addr0 <= '0;
    end else begin
      r_v0 <= valid_i;
      if (valid_i) begin
        r_re0   <= real_i;
        r_im0   <= imag_i;
        r_ch0   <= ch_i;
        r_addr0 <= w_addr_sel;
      end
    end
  end

  nco_sincos_rom #(
    .AW (ROM_AW),
    .CW (CW)
  ) u_rom (
    .clk    (clk),
    .rst    (rst),
    .i_en   (r_v0),
    .i_addr (r_addr0),
    .o_cos  (w_cos),
    .o_sin  (w_sin)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1  <= 1'b0;
      r_re1 <= '0;
      r_im1 <= '0;
      r_ch1 <= '0;
    end else begin
      r_v1 <= r_v0;
      if (r_v0) begin
        r_re1 <= r_re0;
        r_im1 <= r_im0;
        r_ch1 <= r_ch0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v2  <= 1'b0;
      r_ch2 <= '0;
      r_xc  <= '0;
      r_ys  <= '0;
      r_xs  <= '0;
      r_yc  <= '0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_ch2 <= r_ch1;
        r_xc  <= PRW'(r_re1) * PRW'(w_cos);
        r_ys  <= PRW'(r_im1) * PRW'(w_sin);
        r_xs  <= PRW'(r_re1) * PRW'(w_sin);
        r_yc  <= PRW'(r_im1) * PRW'(w_cos);
      end
    end
  end

  assign w_re_sum = SW'(r_xc) - SW'(r_ys);
  assign w_im_sum = SW'(r_xs) + SW'(r_yc);

  always_comb begin
    w_re_sat = 1'b0;
    w_im_sat = 1'b0;
    w_re_q   = DW'(round_sat(64'(w_re_sum), CW - 1, DW, w_re_sat));
    w_im_q   = DW'(round_sat(64'(w_im_sum), CW - 1, DW, w_im_sat));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_o <= 1'b0;
      real_o  <= '0;
      imag_o  <= '0;
      ch_o    <= '0;
      sat_o   <= 1'b0;
    end else begin
      valid_o <= r_v2;
      if (r_v2) begin
        real_o <= w_re_q;
        imag_o <= w_im_q;
        ch_o   <= r_ch2;
        sat_o  <= w_re_sat | w_im_sat;
      end
    end
  end

endmodule

// File: tb/tb_multich_freq_shifter.sv
// Directed, table-driven bench for multich_freq_shifter at default parameters.
module tb_multich_freq_shifter;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [7:0] real_i, imag_i, real_o, imag_o;
  logic [1:0]        ch_i, cfg_ch_i, ch_o;
  logic              valid_i, cfg_we_i, cfg_clr_i, valid_o, sat_o;
  logic [31:0]       cfg_delta_i;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        v;
    int          ch;
    int          re;
    int          im;
    logic        we;
    logic        clr;
    int          cch;
    logic [31:0] delta;
    int          ere;
    int          eim;
    logic        esat;
  } vec_t;

  vec_t tv [48];
  int   n_tv = 0;
  int   t1_end;

  always #5 clk = ~clk;

  multich_freq_shifter dut (
    .clk         (clk),
    .rst         (rst),
    .real_i      (real_i),
    .imag_i      (imag_i),
    .ch_i        (ch_i),
    .valid_i     (valid_i),
    .cfg_we_i    (cfg_we_i),
    .cfg_clr_i   (cfg_clr_i),
    .cfg_ch_i    (cfg_ch_i),
    .cfg_delta_i (cfg_delta_i),
    .real_o      (real_o),
    .imag_o      (imag_o),
    .ch_o        (ch_o),
    .valid_o     (valid_o),
    .sat_o       (sat_o)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic add(input logic v, input int ch, input int re, input int im,
                     input logic we, input logic clr, input int cch, input logic [31:0] d,
                     input int ere, input int eim, input logic esat);
    tv[n_tv] = '{v, ch, re, im, we, clr, cch, d, ere, eim, esat};
    n_tv++;
  endtask

  task automatic idle();
    valid_i = 1'b0; ch_i = '0; real_i = '0; imag_i = '0;
    cfg_we_i = 1'b0; cfg_clr_i = 1'b0; cfg_ch_i = '0; cfg_delta_i = '0;
  endtask

  task automatic drive(input int k);
    valid_i     = tv[k].v;
    ch_i        = 2'(tv[k].ch);
    real_i      = 8'(tv[k].re);
    imag_i      = 8'(tv[k].im);
    cfg_we_i    = tv[k].we;
    cfg_clr_i   = tv[k].clr;
    cfg_ch_i    = 2'(tv[k].cch);
    cfg_delta_i = tv[k].delta;
  endtask

  task automatic check_vec(input int k);
    chk($sformatf("valid_o[%0d]", k), int'(valid_o), int'(tv[k].v));
    if (tv[k].v) begin
      chk($sformatf("real_o[%0d]", k), int'(real_o), tv[k].ere);
      chk($sformatf("imag_o[%0d]", k), int'(imag_o), tv[k].eim);
      chk($sformatf("ch_o[%0d]", k),   int'(ch_o),   tv[k].ch);
      chk($sformatf("sat_o[%0d]", k),  int'(sat_o),  int'(tv[k].esat));
    end
  endtask

  // Vector k is applied before edge k; its result is visible after the fourth edge.
  task automatic play(input int lo, input int hi);
    for (int j = lo; j < hi + 3; j++) begin
      if (j < hi) drive(j);
      else idle();
      @(posedge clk);
      #1;
      if (j - 3 >= lo) check_vec(j - 3);
    end
    idle();
  endtask

  initial begin
    // pass-through, quarter-turn rotation, 45 deg saturation
    add(1, 0,   11,   -5, 0, 0, 0, 32'h0,          11,   -5, 0);
    add(0, 0,    0,    0, 1, 0, 0, 32'h4000_0000,   0,    0, 0);
    add(1, 0,   64,    0, 0, 0, 0, 32'h0,          64,    0, 0);
    add(1, 0,   64,    0, 0, 0, 0, 32'h0,           0,   64, 0);
    add(1, 0,   64,    0, 0, 0, 0, 32'h0,         -63,    0, 0);
    add(1, 0,   64,    0, 0, 0, 0, 32'h0,           0,  -63, 0);
    add(1, 0,   64,    0, 0, 0, 0, 32'h0,          64,    0, 0);
    add(0, 0,    0,    0, 1, 0, 1, 32'h2000_0000,   0,    0, 0);
    add(1, 1, -128, -128, 0, 0, 0, 32'h0,        -127, -127, 0);
    add(1, 1, -128, -128, 0, 0, 0, 32'h0,           0, -128, 1);
    // clear + write together on ch0, ch2 downshift, interleaved
    add(0, 0,    0,    0, 1, 1, 0, 32'h0,           0,    0, 0);
    add(0, 0,    0,    0, 1, 0, 2, 32'hC000_0000,   0,    0, 0);
    add(1, 0,   64,    0, 0, 0, 0, 32'h0,          64,    0, 0);
    add(1, 2,   64,    0, 0, 0, 0, 32'h0,          64,    0, 0);
    add(1, 0,   64,    0, 0, 0, 0, 32'h0,          64,    0, 0);
    add(1, 2,   64,    0, 0, 0, 0, 32'h0,           0,  -63, 0);
    add(1, 0,   64,    0, 0, 0, 0, 32'h0,          64,    0, 0);
    add(1, 2,   64,    0, 0, 0, 0, 32'h0,         -63,    0, 0);
    add(1, 0,   64,    0, 0, 0, 0, 32'h0,          64,    0, 0);
    add(1, 2,   64,    0, 0, 0, 0, 32'h0,           0,   64, 0);
    // clear coinciding with a sample, then delta write coinciding with a sample
    add(1, 2,   64,    0, 0, 0, 0, 32'h0,          64,    0, 0);
    add(1, 2,   64,    0, 0, 1, 2, 32'h0,           0,  -63, 0);
    add(1, 2,   64,    0, 0, 0, 0, 32'h0,          64,    0, 0);
    add(1, 2,   64,    0, 1, 0, 2, 32'h8000_0000,   0,  -63, 0);
    add(1, 2,   64,    0, 0, 0, 0, 32'h0,         -63,    0, 0);
    add(1, 2,   64,    0, 0, 0, 0, 32'h0,          64,    0, 0);
    add(0, 0,    0,    0, 0, 0, 0, 32'h0,           0,    0, 0);
    t1_end = n_tv;
    // after mid-stream reset: deltas cleared, phases start at 0
    add(1, 1,   64,    0, 0, 0, 0, 32'h0,          64,    0, 0);
    add(1, 1,   64,    0, 0, 0, 0, 32'h0,          64,    0, 0);
    add(0, 0,    0,    0, 1, 0, 0, 32'h4000_0000,   0,    0, 0);
    add(1, 0,   64,    0, 0, 0, 0, 32'h0,          64,    0, 0);
    add(1, 0,   64,    0, 0, 0, 0, 32'h0,           0,   64, 0);
    add(1, 0, -128,    0, 0, 0, 0, 32'h0,         127,    0, 0);
    add(1, 0, -128, -128, 0, 0, 0, 32'h0,        -127,  127, 0);
    add(1, 3, -128,  127, 0, 0, 0, 32'h0,        -127,  126, 0);

    idle();
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset valid_o", int'(valid_o), 0);
    chk("reset real_o",  int'(real_o),  0);
    chk("reset imag_o",  int'(imag_o),  0);
    chk("reset ch_o",    int'(ch_o),    0);
    chk("reset sat_o",   int'(sat_o),   0);
    @(negedge clk) rst = 1'b1;

    play(0, t1_end);

    // four ch1 samples: first reaches the output, three still in flight
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1; ch_i = 2'd1; real_i = 8'sd64; imag_i = 8'sd0;
      @(posedge clk);
      #1;
    end
    idle();
    chk("pre-reset valid_o", int'(valid_o), 1);
    chk("pre-reset imag_o",  int'(imag_o),  64);
    #1 rst = 1'b0;
    #1;
    chk("async reset valid_o", int'(valid_o), 0);
    chk("async reset real_o",  int'(real_o),  0);
    chk("async reset imag_o",  int'(imag_o),  0);
    @(posedge clk);
    #1;
    chk("held reset valid_o", int'(valid_o), 0);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post-reset flush valid_o[%0d]", i), int'(valid_o), 0);
    end

    play(t1_end, n_tv);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
